data_path_n: RTL and testbench

- Parametrised successor of the 8-bit accumulator data path.
- Generalised to WIDTH-bit data, NREGS general registers (replacing fixed A/B) and an internal ALU with NZVC flags.
- Adds a hardware stack pointer with push/pop addressing.
- Sits between the control unit (drives load/select strobes, reads IR/CCR) and the unified memory (address/to_memory/from_memory).

---
 rtl/data_path_n.sv | 217 +++++++++++++++++++++
 tb/tb_data_path_n.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path_n.sv
// Parametrised accumulator data path: NREGS general registers, NZVC ALU,
// PC, MAR, IR, CCR and a pre-decrement/post-increment hardware stack pointer.
module data_path_n #(
    parameter int               WIDTH   = 8,
    parameter int               NREGS   = 4,
    parameter logic [WIDTH-1:0] SP_INIT = {WIDTH{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         from_memory,
    input  logic                     ir_load,
    input  logic                     ccr_load,
    input  logic                     mar_load,
    input  logic                     pc_load,
    input  logic                     pc_inc,
    input  logic                     reg_load,
    input  logic [$clog2(NREGS)-1:0] reg_wsel,
    input  logic [$clog2(NREGS)-1:0] reg_asel,
    input  logic [$clog2(NREGS)-1:0] reg_bsel,
    input  logic [2:0]               alu_sel,
    input  logic [1:0]               from_bus_sel,
    input  logic [2:0]               to_bus_sel,
    input  logic                     sp_push,
    input  logic                     sp_pop,
    output logic [WIDTH-1:0]         ir,
    output logic [3:0]               ccr,
    output logic [WIDTH-1:0]         address,
    output logic [WIDTH-1:0]         to_memory
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_INC  = 3'b101,
        ALU_DEC  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        TO_PC   = 3'b000,
        TO_RA   = 3'b001,
        TO_RB   = 3'b010,
        TO_SP   = 3'b011,
        TO_CCR  = 3'b100,
        TO_NONE = 3'b101
    } to_sel_e;

    typedef enum logic [1:0] {
        FROM_ALU  = 2'b00,
        FROM_TO   = 2'b01,
        FROM_MEM  = 2'b10,
        FROM_ZERO = 2'b11
    } from_sel_e;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] sp_q;
    logic [WIDTH-1:0] mar_q;
    logic [WIDTH-1:0] ir_q;
    logic [3:0]       ccr_q;
    logic [WIDTH-1:0] regs [NREGS];

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   a_x;
    logic [WIDTH:0]   b_x;
    logic [WIDTH:0]   alu_wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_c;
    logic [3:0]       alu_flags;
    logic [WIDTH-1:0] to_bus;
    logic [WIDTH-1:0] from_bus;
    logic [WIDTH-1:0] sp_dec;
    logic [WIDTH-1:0] sp_inc;
    logic             push_only;
    logic             pop_only;

    localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    assign op_a = regs[reg_asel];
    assign op_b = regs[reg_bsel];
    assign a_x  = {1'b0, op_a};
    assign b_x  = {1'b0, op_b};

    // Arithmetic is done one bit wider so carry/borrow falls out of the top bit.
    always_comb begin
        alu_wide = '0;
        alu_v    = 1'b0;
        alu_c    = 1'b0;
        case (alu_op_e'(alu_sel))
            ALU_ADD: begin
                alu_wide = a_x + b_x;
                alu_c    = alu_wide[WIDTH];
                alu_v    = (op_a[MSB] == op_b[MSB]) && (alu_wide[MSB] != op_a[MSB]);
            end
            ALU_SUB: begin
                alu_wide = a_x - b_x;
                alu_c    = alu_wide[WIDTH];
                alu_v    = (op_a[MSB] != op_b[MSB]) && (alu_wide[MSB] != op_a[MSB]);
            end
            ALU_AND: alu_wide = a_x & b_x;
            ALU_OR:  alu_wide = a_x | b_x;
            ALU_XOR: alu_wide = a_x ^ b_x;
            ALU_INC: begin
                alu_wide = a_x + ONE_X;
                alu_c    = alu_wide[WIDTH];
                alu_v    = !op_a[MSB] && alu_wide[MSB];
            end
            ALU_DEC: begin
                alu_wide = a_x - ONE_X;
                alu_c    = alu_wide[WIDTH];
                alu_v    = op_a[MSB] && !alu_wide[MSB];
            end
            default: alu_wide = b_x;
        endcase
    end

    assign alu_res   = alu_wide[MSB:0];
    assign alu_flags = {alu_res[MSB], (alu_res == '0), alu_v, alu_c};

    always_comb begin
        to_bus = '0;
        case (to_sel_e'(to_bus_sel))
            TO_PC:   to_bus = pc_q;
            TO_RA:   to_bus = op_a;
            TO_RB:   to_bus = op_b;
            TO_SP:   to_bus = sp_q;
            TO_CCR:  to_bus[3:0] = ccr_q;
            default: to_bus = '0;
        endcase
    end

    always_comb begin
        from_bus = '0;
        case (from_sel_e'(from_bus_sel))
            FROM_ALU:  from_bus = alu_res;
            FROM_TO:   from_bus = to_bus;
            FROM_MEM:  from_bus = from_memory;
            default:   from_bus = '0;
        endcase
    end

    // A simultaneous push and pop cancel out rather than picking a winner.
    assign push_only = sp_push && !sp_pop;
    assign pop_only  = sp_pop && !sp_push;
    assign sp_dec    = sp_q - ONE_W;
    assign sp_inc    = sp_q + ONE_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= SP_INIT;
        end else if (push_only) begin
            sp_q <= sp_dec;
        end else if (pop_only) begin
            sp_q <= sp_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mar_q <= '0;
        end else if (mar_load) begin
            mar_q <= from_bus;
        end else if (push_only) begin
            mar_q <= sp_dec;
        end else if (pop_only) begin
            mar_q <= sp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else if (pc_load) begin
            pc_q <= from_bus;
        end else if (pc_inc) begin
            pc_q <= pc_q + ONE_W;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q  <= '0;
            ccr_q <= 4'b0000;
        end else begin
            if (ir_load) begin
                ir_q <= from_bus;
            end
            if (ccr_load) begin
                ccr_q <= alu_flags;
            end
        end
    end

    // Reads above use the pre-edge values, so read-modify-write in one cycle is safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_load) begin
            regs[reg_wsel] <= from_bus;
        end
    end

    assign ir        = ir_q;
    assign ccr       = ccr_q;
    assign address   = mar_q;
    assign to_memory = to_bus;

endmodule

// File: tb/tb_data_path_n.sv
// Directed bench for data_path_n: an 8-bit/4-register instance plus a
// 16-bit/8-register instance for the parameter sweep.
module tb_data_path_n;

    logic clk;
    logic reset;

    logic [7:0]  from_memory;
    logic        ir_load, ccr_load, mar_load, pc_load, pc_inc, reg_load;
    logic [1:0]  reg_wsel, reg_asel, reg_bsel;
    logic [2:0]  alu_sel;
    logic [1:0]  from_bus_sel;
    logic [2:0]  to_bus_sel;
    logic        sp_push, sp_pop;
    logic [7:0]  ir, address, to_memory;
    logic [3:0]  ccr;

    logic [15:0] from_memory16;
    logic        ir_load16, ccr_load16, mar_load16, pc_load16, pc_inc16, reg_load16;
    logic [2:0]  reg_wsel16, reg_asel16, reg_bsel16;
    logic [2:0]  alu_sel16;
    logic [1:0]  from_bus_sel16;
    logic [2:0]  to_bus_sel16;
    logic        sp_push16, sp_pop16;
    logic [15:0] ir16, address16, to_memory16;
    logic [3:0]  ccr16;

    int compared;
    int mismatched;

    data_path_n u_dut8 (
        .clk(clk), .reset(reset), .from_memory(from_memory),
        .ir_load(ir_load), .ccr_load(ccr_load), .mar_load(mar_load),
        .pc_load(pc_load), .pc_inc(pc_inc), .reg_load(reg_load),
        .reg_wsel(reg_wsel), .reg_asel(reg_asel), .reg_bsel(reg_bsel),
        .alu_sel(alu_sel), .from_bus_sel(from_bus_sel), .to_bus_sel(to_bus_sel),
        .sp_push(sp_push), .sp_pop(sp_pop),
        .ir(ir), .ccr(ccr), .address(address), .to_memory(to_memory)
    );

    data_path_n #(.WIDTH(16), .NREGS(8)) u_dut16 (
        .clk(clk), .reset(reset), .from_memory(from_memory16),
        .ir_load(ir_load16), .ccr_load(ccr_load16), .mar_load(mar_load16),
        .pc_load(pc_load16), .pc_inc(pc_inc16), .reg_load(reg_load16),
        .reg_wsel(reg_wsel16), .reg_asel(reg_asel16), .reg_bsel(reg_bsel16),
        .alu_sel(alu_sel16), .from_bus_sel(from_bus_sel16), .to_bus_sel(to_bus_sel16),
        .sp_push(sp_push16), .sp_pop(sp_pop16),
        .ir(ir16), .ccr(ccr16), .address(address16), .to_memory(to_memory16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge with the current strobes, then all strobes drop back to idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        ir_load = 0; ccr_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0;
        reg_load = 0; sp_push = 0; sp_pop = 0;
        ir_load16 = 0; ccr_load16 = 0; mar_load16 = 0; pc_load16 = 0; pc_inc16 = 0;
        reg_load16 = 0; sp_push16 = 0; sp_pop16 = 0;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic viewTo(input logic [2:0] sel, input logic [1:0] a, input logic [1:0] b);
        to_bus_sel = sel; reg_asel = a; reg_bsel = b;
        #1;
    endtask

    task automatic loadReg(input logic [1:0] idx, input logic [7:0] value);
        reg_load = 1; reg_wsel = idx; from_bus_sel = 2'b10; from_memory = value;
        applyStimulus();
    endtask

    task automatic aluOp(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic wr, input logic [1:0] dst);
        alu_sel = op; reg_asel = a; reg_bsel = b; from_bus_sel = 2'b00;
        ccr_load = 1; reg_load = wr; reg_wsel = dst;
        applyStimulus();
    endtask

    initial begin
        compared = 0; mismatched = 0;
        reset = 1;
        from_memory = 0; ir_load = 0; ccr_load = 0; mar_load = 0; pc_load = 0;
        pc_inc = 0; reg_load = 0; reg_wsel = 0; reg_asel = 0; reg_bsel = 0;
        alu_sel = 0; from_bus_sel = 0; to_bus_sel = 0; sp_push = 0; sp_pop = 0;
        from_memory16 = 0; ir_load16 = 0; ccr_load16 = 0; mar_load16 = 0; pc_load16 = 0;
        pc_inc16 = 0; reg_load16 = 0; reg_wsel16 = 0; reg_asel16 = 0; reg_bsel16 = 0;
        alu_sel16 = 0; from_bus_sel16 = 0; to_bus_sel16 = 0; sp_push16 = 0; sp_pop16 = 0;
        applyStimulus();
        applyStimulus();

        // Reset must override every strobe.
        pc_inc = 1; reg_load = 1; reg_wsel = 0; from_bus_sel = 2'b10; from_memory = 8'h55;
        sp_push = 1; ccr_load = 1; mar_load = 1; ir_load = 1;
        applyStimulus();
        viewTo(3'b000, 0, 0);
        checkOutput("rst_to_memory_pc", to_memory, 8'h00);
        checkOutput("rst_address", address, 8'h00);
        checkOutput("rst_ccr", ccr, 4'b0000);
        checkOutput("rst_ir", ir, 8'h00);
        viewTo(3'b011, 0, 0);
        checkOutput("rst_sp", to_memory, 8'hFF);
        viewTo(3'b001, 0, 0);
        checkOutput("rst_r0", to_memory, 8'h00);
        to_bus_sel16 = 3'b011; #1;
        checkOutput("rst_sp16", to_memory16, 16'hFFFF);
        reset = 0;

        loadReg(1, 8'h7F);
        loadReg(2, 8'h01);
        viewTo(3'b001, 1, 2);
        checkOutput("r1_load", to_memory, 8'h7F);
        viewTo(3'b010, 1, 2);
        checkOutput("r2_load", to_memory, 8'h01);

        aluOp(3'b000, 1, 2, 1, 3);
        checkOutput("add_ccr", ccr, 4'b1010);
        viewTo(3'b001, 3, 0);
        checkOutput("add_r3", to_memory, 8'h80);

        reg_load = 1; reg_wsel = 1; from_bus_sel = 2'b11; from_memory = 8'hAA;
        applyStimulus();
        aluOp(3'b001, 1, 2, 1, 0);
        checkOutput("sub_ccr", ccr, 4'b1001);
        viewTo(3'b001, 0, 0);
        checkOutput("sub_r0", to_memory, 8'hFF);

        loadReg(1, 8'hF0);
        loadReg(2, 8'h0F);
        aluOp(3'b010, 1, 2, 0, 0);
        checkOutput("and_ccr", ccr, 4'b0100);
        viewTo(3'b001, 0, 0);
        checkOutput("and_no_write_r0", to_memory, 8'hFF);
        aluOp(3'b100, 1, 2, 1, 3);
        checkOutput("xor_ccr", ccr, 4'b1000);
        viewTo(3'b001, 3, 0);
        checkOutput("xor_r3", to_memory, 8'hFF);
        aluOp(3'b011, 1, 2, 0, 0);
        checkOutput("or_ccr", ccr, 4'b1000);
        aluOp(3'b111, 1, 2, 1, 0);
        checkOutput("pass_ccr", ccr, 4'b0000);
        viewTo(3'b001, 0, 0);
        checkOutput("pass_r0", to_memory, 8'h0F);
        aluOp(3'b000, 3, 3, 0, 0);
        checkOutput("add_carry_ccr", ccr, 4'b1001);

        loadReg(1, 8'h7F);
        aluOp(3'b101, 1, 0, 1, 1);
        checkOutput("inc_ccr", ccr, 4'b1010);
        viewTo(3'b001, 1, 0);
        checkOutput("inc_rmw_r1", to_memory, 8'h80);
        aluOp(3'b110, 1, 0, 0, 0);
        checkOutput("dec_ccr", ccr, 4'b0010);
        loadReg(2, 8'h00);
        aluOp(3'b110, 2, 0, 0, 0);
        checkOutput("dec_zero_ccr", ccr, 4'b1001);
        loadReg(2, 8'hFF);
        aluOp(3'b101, 2, 0, 0, 0);
        checkOutput("inc_wrap_ccr", ccr, 4'b0101);

        viewTo(3'b100, 0, 0);
        checkOutput("to_ccr", to_memory, 8'h05);
        viewTo(3'b101, 0, 0);
        checkOutput("to_101", to_memory, 8'h00);
        viewTo(3'b111, 0, 0);
        checkOutput("to_111", to_memory, 8'h00);

        viewTo(3'b001, 1, 0);
        ir_load = 1; from_bus_sel = 2'b01;
        applyStimulus();
        checkOutput("ir_from_to_bus", ir, 8'h80);

        pc_load = 1; from_bus_sel = 2'b10; from_memory = 8'hFF;
        applyStimulus();
        pc_inc = 1;
        applyStimulus();
        viewTo(3'b000, 0, 0);
        checkOutput("pc_wrap", to_memory, 8'h00);
        pc_load = 1; pc_inc = 1; from_bus_sel = 2'b10; from_memory = 8'h40;
        applyStimulus();
        checkOutput("pc_load_prio", to_memory, 8'h40);
        pc_inc = 1;
        applyStimulus();
        checkOutput("pc_inc", to_memory, 8'h41);

        to_bus_sel = 3'b011;
        sp_push = 1; applyStimulus();
        checkOutput("push_sp", to_memory, 8'hFE);
        checkOutput("push_mar", address, 8'hFE);
        sp_pop = 1; applyStimulus();
        checkOutput("pop_sp", to_memory, 8'hFF);
        checkOutput("pop_mar", address, 8'hFE);
        sp_push = 1; sp_pop = 1; applyStimulus();
        checkOutput("pushpop_sp", to_memory, 8'hFF);
        checkOutput("pushpop_mar", address, 8'hFE);
        sp_push = 1; mar_load = 1; from_bus_sel = 2'b10; from_memory = 8'h10;
        applyStimulus();
        checkOutput("push_marload_mar", address, 8'h10);
        checkOutput("push_marload_sp", to_memory, 8'hFE);
        sp_pop = 1; applyStimulus();
        sp_pop = 1; applyStimulus();
        checkOutput("pop_wrap_mar", address, 8'hFF);
        checkOutput("pop_wrap_sp", to_memory, 8'h00);
        sp_push = 1; applyStimulus();
        checkOutput("push_wrap_sp", to_memory, 8'hFF);
        checkOutput("push_wrap_mar", address, 8'hFF);

        reg_load16 = 1; reg_wsel16 = 3'd7; from_bus_sel16 = 2'b10; from_memory16 = 16'hA5C3;
        applyStimulus();
        to_bus_sel16 = 3'b001; reg_asel16 = 3'd7; reg_bsel16 = 3'd7; #1;
        checkOutput("w16_r7_port_a", to_memory16, 16'hA5C3);
        to_bus_sel16 = 3'b010; reg_asel16 = 3'd0; #1;
        checkOutput("w16_r7_port_b", to_memory16, 16'hA5C3);
        to_bus_sel16 = 3'b001; #1;
        checkOutput("w16_r0", to_memory16, 16'h0000);
        reg_asel16 = 3'd7; alu_sel16 = 3'b000; from_bus_sel16 = 2'b00;
        ccr_load16 = 1; reg_load16 = 1; reg_wsel16 = 3'd6;
        applyStimulus();
        checkOutput("w16_add_ccr", ccr16, 4'b0011);
        reg_asel16 = 3'd6; to_bus_sel16 = 3'b001; #1;
        checkOutput("w16_add_r6", to_memory16, 16'h4B86);
        to_bus_sel16 = 3'b011; #1;
        checkOutput("w16_sp_idle", to_memory16, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
